// File: rtl/irq_gateway_pkg.sv
// Shared core package: privilege/mcause encodings plus interrupt gateway types.
// Pulled in by the gateway and its source latch with import irq_gateway_pkg::*.
package irq_gateway_pkg;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } privilege_e;

   typedef enum logic [4:0] {
      MCAUSE_MSI = 5'd3,
      MCAUSE_MTI = 5'd7,
      MCAUSE_MEI = 5'd11
   } mcause_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      HOLDOFF = 2'd2
   } irq_state_e;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      EXT   = 2'd1,
      SOFT  = 2'd2,
      TIMER = 2'd3
   } irq_sel_e;

   localparam int unsigned HOLDOFF_CNT_W = 4;

   // elig is {ext, soft, timer}; order matches the controller's mcause decode
   function automatic irq_sel_e irq_arbitrate(input logic [2:0] elig);
      irq_sel_e sel;
      sel = NONE;
      if (elig[2]) begin
         sel = EXT;
      end else if (elig[1]) begin
         sel = SOFT;
      end else if (elig[0]) begin
         sel = TIMER;
      end
      return sel;
   endfunction

   function automatic mcause_e irq_sel_to_mcause(input irq_sel_e sel);
      mcause_e cause;
      cause = MCAUSE_MEI;
      if (sel == SOFT) begin
         cause = MCAUSE_MSI;
      end else if (sel == TIMER) begin
         cause = MCAUSE_MTI;
      end
      return cause;
   endfunction

endpackage

// File: rtl/irq_gateway_src_latch.sv
// irq_src_latch: per-source input register and pending flop.
// EDGE_EN selects rising-edge capture with ack-driven clear; otherwise level.
module irq_src_latch
   import irq_gateway_pkg::*;
#(
   parameter bit EDGE_EN = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic irq_in,
   input  logic clr,
   output logic pending
);

   logic in_q;
   logic in_d;
   logic pend_q;
   logic pend_d;
   logic rise;

   always_comb begin
      in_d = irq_in;
      rise = irq_in & ~in_q;
      // a fresh edge coinciding with the clearing ack keeps the source pending
      if (EDGE_EN) begin
         pend_d = rise | (pend_q & ~clr);
      end else begin
         pend_d = irq_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         in_q   <= in_d;
         pend_q <= pend_d;
      end
   end

   assign pending = pend_q;

endmodule

// File: rtl/irq_gateway.sv
// Machine interrupt gateway: gates, arbitrates and holds one taken request.
// Define IRQ_EXT_EDGE_EN for an edge-triggered external interrupt (meip).
module irq_gateway
   import irq_gateway_pkg::*;
#(
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ext_irq,
   input  logic soft_irq,
   input  logic timer_irq,
   input  logic mstatus_mie,
   input  logic mie_meie,
   input  logic mie_msie,
   input  logic mie_mtie,
   input  logic core_sleep,
   input  logic irq_ack,
   output logic extern_irq_taken,
   output logic soft_irq_taken,
   output logic timer_irq_taken,
   output logic mip_meip,
   output logic mip_msip,
   output logic mip_mtip
);

`ifdef IRQ_EXT_EDGE_EN
   localparam bit EXT_EDGE = 1'b1;
`else
   localparam bit EXT_EDGE = 1'b0;
`endif

   localparam logic [HOLDOFF_CNT_W-1:0] HOLDOFF_LOAD =
      HOLDOFF_CNT_W'(HOLDOFF_CYCLES - 1);

   irq_state_e state_q;
   irq_state_e state_d;
   irq_sel_e   sel_q;
   irq_sel_e   sel_d;
   irq_sel_e   arb_sel;
   logic [HOLDOFF_CNT_W-1:0] cnt_q;
   logic [HOLDOFF_CNT_W-1:0] cnt_d;

   logic       ext_pend;
   logic       soft_pend;
   logic       timer_pend;
   logic       ext_clr;
   logic       glb_en;
   logic [2:0] elig;
   logic       in_pending;

   assign in_pending = (state_q == PENDING);
   assign ext_clr    = in_pending & irq_ack & (sel_q == EXT);

   irq_src_latch #(.EDGE_EN(EXT_EDGE)) u_ext (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (ext_irq),
      .clr     (ext_clr),
      .pending (ext_pend)
   );

   irq_src_latch #(.EDGE_EN(1'b0)) u_soft (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (soft_irq),
      .clr     (1'b0),
      .pending (soft_pend)
   );

   irq_src_latch #(.EDGE_EN(1'b0)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (timer_irq),
      .clr     (1'b0),
      .pending (timer_pend)
   );

   // WFI wake bypasses the global enable but still honours mie
   always_comb begin
      glb_en  = mstatus_mie | core_sleep;
      elig[2] = ext_pend   & mie_meie & glb_en;
      elig[1] = soft_pend  & mie_msie & glb_en;
      elig[0] = timer_pend & mie_mtie & glb_en;
      arb_sel = irq_arbitrate(elig);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (arb_sel != NONE) begin
               sel_d   = arb_sel;
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (irq_ack) begin
               state_d = HOLDOFF;
               cnt_d   = HOLDOFF_LOAD;
            end
         end
         HOLDOFF: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sel_q   <= NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   assign extern_irq_taken = in_pending & (sel_q == EXT);
   assign soft_irq_taken   = in_pending & (sel_q == SOFT);
   assign timer_irq_taken  = in_pending & (sel_q == TIMER);

   assign mip_meip = ext_pend;
   assign mip_msip = soft_pend;
   assign mip_mtip = timer_pend;

endmodule

// File: doc/irq_gateway.md
# irq_gateway

Interrupt gateway that sits directly upstream of the pipeline controller. It samples the machine external, software and timer interrupt sources and gates them with the `mie`/`mstatus.MIE` enables. It then arbitrates them into one held, one-hot "taken" request toward the controller and retires that request on the controller's `irq_ack`. It also exports the pending bits for the `mip` CSR read path.

## Interface

Parameters:
- `HOLDOFF_CYCLES`, default 2: cycles after an ack during which no new taken request is raised (range 1..15).

Ports:
- `clk`  input  1  core clock
- `reset_n`  input  1  asynchronous active-low reset
- `ext_irq`  input  1  external interrupt line from the platform
- `soft_irq`  input  1  software interrupt line (msip)
- `timer_irq`  input  1  timer interrupt line (mtimecmp)
- `mstatus_mie`  input  1  global machine interrupt enable
- `mie_meie`, `mie_msie`, `mie_mtie`  input  1 each  per-source enables
- `core_sleep`  input  1  core is in WFI sleep (inverse of controller `fetch_enable`)
- `irq_ack`  input  1  controller acknowledge of the current request
- `extern_irq_taken`, `soft_irq_taken`, `timer_irq_taken`  output  1 each  one-hot request to the controller
- `mip_meip`, `mip_msip`, `mip_mtip`  output  1 each  pending bits for CSR read

## Operation

- Each source has a pending flop. In level mode, pending = the registered input line.
- A source is eligible when pending & its `mie_*` bit & (`mstatus_mie` | `core_sleep`). WFI wake ignores the global enable, per the privileged spec.
- Fixed priority is external > software > timer, matching the controller's mcause decode.
- State machine, state held in 2 bits:
  - IDLE: the selection is latched on any eligible source → PENDING.
  - PENDING: exactly one taken output is high, driven from the latched selection. It stays stable regardless of enable or pending changes. `irq_ack` high → HOLDOFF, with the counter loaded to `HOLDOFF_CYCLES-1`.
  - HOLDOFF: all taken outputs are low. The counter decrements each cycle; at 0 → IDLE.
- Pending flops keep sampling in every state. A source arriving during PENDING or HOLDOFF is arbitrated on the first IDLE cycle.
- `irq_ack` while in IDLE or HOLDOFF is ignored.
- Taken outputs stay high during the ack cycle itself, because the controller reads them in that cycle to build mcause.
- Reset mid-operation: all flops clear asynchronously and the state goes to IDLE. Any in-flight request is dropped.

## Timing

- Reset values:
  - all taken outputs 0
  - all `mip_*` outputs 0
  - state IDLE
  - counter 0
- Latency:
  - Source rises before edge N → pending (and `mip_*`) high after edge N.
  - If eligible, state = PENDING and taken is high after edge N+1, so taken is visible 2 cycles after the input.
- Ack:
  - `irq_ack` sampled high at edge M → taken low after edge M.
  - The next taken is possible no earlier than after edge M+`HOLDOFF_CYCLES`+1.
- Simultaneous sources in the same cycle → the highest priority wins. The others remain pending.
- Enables dropping during PENDING → no effect until ack.
- A level source held high through HOLDOFF is re-taken after HOLDOFF, at the earliest edge allowed by the ack rule above.

## Configuration

- `IRQ_EXT_EDGE_EN` defined:
  - `meip` becomes edge-triggered. The pending flop sets on a registered rising edge of `ext_irq`.
  - It clears on the cycle `irq_ack` is sampled while the latched selection is external.
  - A new rising edge in the same cycle as that clearing ack wins, and pending stays set.
- Not defined: `meip` is level-sensitive like the other two sources and is never cleared by ack.
- In both modes, software and timer are always level-sensitive.

## Structure

- Shared package (the one holding `mcause_e`/`privilege_e`):
  - `irq_state_e` (IDLE, PENDING, HOLDOFF)
  - `irq_sel_e` (NONE, EXT, SOFT, TIMER)
- One sub-module, `irq_src_latch`: a per-source input register plus pending flop, instantiated three times. The edge option applies only to the external instance.

## Test plan

- `timer_irq`=1, `mie_mtie`=1, `mstatus_mie`=1, ack at the first cycle taken is seen → `timer_irq_taken` rises 2 cycles after input, falls the cycle after ack, and re-rises 3 cycles later with `HOLDOFF_CYCLES`=2 while the line is held.
- All three sources rise together, all enabled → `extern_irq_taken` only. After ack and holdoff with `ext_irq` low → `soft_irq_taken`. Then → `timer_irq_taken`.
- `mstatus_mie`=0, `soft_irq`=1, `mie_msie`=1 → no taken for 20 cycles. Then `core_sleep`=1 → `soft_irq_taken` 1 cycle later.
- During PENDING(ext), `mie_meie` goes to 0 and `timer_irq` goes to 1 → `extern_irq_taken` stays high and one-hot until ack.
- `IRQ_EXT_EDGE_EN`: a 1-cycle `ext_irq` pulse → `mip_meip` latches and `extern_irq_taken` follows. Ack → `mip_meip` clears and there is no re-take.
- Assert `reset_n`=0 for 1 cycle while in PENDING → all outputs 0 immediately and state IDLE. With the sources held, taken reappears 2 cycles after reset release.
